// File: rtl/config_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_stream_loader
// Purpose  : Unpacks a header/(addr,data)/checksum stream onto the tile
//            array's broadcast config_addr/config_data bus.
// Revision : 1.0 - initial release
// ============================================================================
module config_stream_loader #(
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] pairs_written
);

    localparam logic [COUNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [COUNT_W-1:0] c_CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [COUNT_W-1:0]   r_remaining;
    logic [31:0]          r_addr_reg;
    logic [31:0]          r_checksum;
    logic [31:0]          r_config_addr;
    logic [31:0]          r_config_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [COUNT_W-1:0]   r_pairs_written;

    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b1;
        case (r_state)
            S_HDR: begin
                if (w_accept) begin
                    w_next_state = (in_data[COUNT_W-1:0] != c_CNT_ZERO) ? S_ADDR : S_CHECK;
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_in_ready   = 1'b0;
                // Last pair when the counter is about to reach zero.
                w_next_state = (r_remaining != c_CNT_ONE) ? S_ADDR : S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_in_ready   = 1'b0;
                w_next_state = S_HDR;
            end
            default: begin
                w_next_state = S_HDR;
            end
        endcase
    end

    // The bus is loaded on the DATA accept so it is already valid, from a
    // register, throughout the WRITE cycle; it reverts to idle the cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining     <= c_CNT_ZERO;
            r_addr_reg      <= 32'h0;
            r_checksum      <= 32'h0;
            r_config_addr   <= IDLE_ADDR;
            r_config_data   <= 32'h0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_pairs_written <= c_CNT_ZERO;
        end else begin
            r_done        <= 1'b0;
            r_config_addr <= IDLE_ADDR;
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_remaining     <= in_data[COUNT_W-1:0];
                        r_checksum      <= in_data;
                        r_pairs_written <= c_CNT_ZERO;
                        r_error         <= 1'b0;
                        r_busy          <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        r_addr_reg <= in_data;
                        r_checksum <= r_checksum ^ in_data;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_config_data <= in_data;
                        r_config_addr <= r_addr_reg;
                        r_checksum    <= r_checksum ^ in_data;
                    end
                end
                S_WRITE: begin
                    r_pairs_written <= r_pairs_written + c_CNT_ONE;
                    r_remaining     <= r_remaining - c_CNT_ONE;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_error <= (in_data != r_checksum);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready      = w_in_ready;
    assign config_addr   = r_config_addr;
    assign config_data   = r_config_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign pairs_written = r_pairs_written;

endmodule
`default_nettype wire
